// File: rtl/multi_zone_alarm_ctrl.sv
// Multi-zone intrusion alarm controller: entry delay, timed siren with re-trigger,
// sticky zone-of-origin latch and refused-arm fault. Define MULTI_ZONE_TAMPER_EN for the tamper input/flag.
module multi_zone_alarm_ctrl #(
    parameter int NUM_ZONES    = 4,
    parameter int CNT_W        = 8,
    parameter int ENTRY_DELAY  = 16,
    parameter int SIREN_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] sensor,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic [NUM_ZONES-1:0] instant,
`ifdef MULTI_ZONE_TAMPER_EN
    input  logic                 tamper,
    output logic                 tamper_flag,
`endif
    output logic                 alarm,
    output logic [2:0]           state,
    output logic [NUM_ZONES-1:0] zone_latch,
    output logic                 arm_fault,
    output logic [CNT_W-1:0]     count
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_ENTRY    = 3'd2,
        S_ALARM    = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    state_t               r_state;
    logic                 r_alarm;
    logic [NUM_ZONES-1:0] r_zone_latch;
    logic                 r_arm_fault;
    logic [CNT_W-1:0]     r_count;

    state_t               w_nxt_state;
    logic                 w_nxt_alarm;
    logic [NUM_ZONES-1:0] w_nxt_latch;
    logic                 w_nxt_fault;
    logic [CNT_W-1:0]     w_nxt_count;
    logic [NUM_ZONES-1:0] w_act;
    logic [NUM_ZONES-1:0] w_inst;
    logic                 w_cnt_zero;

    assign w_act      = sensor & zone_en;
    assign w_inst     = w_act & instant;
    assign w_cnt_zero = (r_count == '0);

    // Count defaults to 0 so that every state not loading or decrementing reads 0.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_alarm = 1'b0;
        w_nxt_latch = r_zone_latch;
        w_nxt_fault = 1'b0;
        w_nxt_count = '0;
        if (disarm) begin
            w_nxt_state = S_DISARMED;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    if (arm) begin
                        if (|w_act) begin
                            w_nxt_fault = 1'b1;
                        end else begin
                            w_nxt_state = S_ARMED;
                            w_nxt_latch = '0;
                        end
                    end
                end
                S_ARMED: begin
                    w_nxt_latch = r_zone_latch | w_act;
                    if (|w_inst) begin
                        w_nxt_state = S_ALARM;
                        w_nxt_alarm = 1'b1;
                        w_nxt_count = SIREN_LOAD;
                    end else if (|w_act) begin
                        w_nxt_state = S_ENTRY;
                        w_nxt_count = ENTRY_LOAD;
                    end
                end
                S_ENTRY: begin
                    w_nxt_latch = r_zone_latch | w_act;
                    if ((|w_inst) || w_cnt_zero) begin
                        w_nxt_state = S_ALARM;
                        w_nxt_alarm = 1'b1;
                        w_nxt_count = SIREN_LOAD;
                    end else begin
                        w_nxt_count = r_count - CNT_W'(1);
                    end
                end
                S_ALARM: begin
                    w_nxt_latch = r_zone_latch | w_act;
                    if (w_cnt_zero) begin
                        w_nxt_state = S_HOLDOFF;
                    end else begin
                        w_nxt_alarm = 1'b1;
                        w_nxt_count = r_count - CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    w_nxt_latch = r_zone_latch | w_act;
                    if (|w_act) begin
                        w_nxt_state = S_ALARM;
                        w_nxt_alarm = 1'b1;
                        w_nxt_count = SIREN_LOAD;
                    end
                end
                default: w_nxt_state = S_DISARMED;
            endcase
        end
`ifdef MULTI_ZONE_TAMPER_EN
        // Tamper overrides everything, disarm included.
        if (tamper) begin
            w_nxt_state = S_ALARM;
            w_nxt_alarm = 1'b1;
            w_nxt_count = SIREN_LOAD;
            w_nxt_fault = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_DISARMED;
            r_alarm      <= 1'b0;
            r_zone_latch <= '0;
            r_arm_fault  <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_alarm      <= w_nxt_alarm;
            r_zone_latch <= w_nxt_latch;
            r_arm_fault  <= w_nxt_fault;
            r_count      <= w_nxt_count;
        end
    end

`ifdef MULTI_ZONE_TAMPER_EN
    logic r_tamper_flag;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tamper_flag <= 1'b0;
        else        r_tamper_flag <= r_tamper_flag | tamper;
    end
    assign tamper_flag = r_tamper_flag;
`endif

    assign alarm      = r_alarm;
    assign state      = r_state;
    assign zone_latch = r_zone_latch;
    assign arm_fault  = r_arm_fault;
    assign count      = r_count;

endmodule

// File: tb/tb_multi_zone_alarm_ctrl.sv
// Directed scoreboard bench for multi_zone_alarm_ctrl (default parameters).
module tb_multi_zone_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm, disarm;
    logic [3:0] sensor, zone_en, instant;
    logic       alarm;
    logic [2:0] state;
    logic [3:0] zone_latch;
    logic       arm_fault;
    logic [7:0] count;
`ifdef MULTI_ZONE_TAMPER_EN
    logic       tamper;
    logic       tamper_flag;
`endif

    always #5 clk = ~clk;

    multi_zone_alarm_ctrl #(
        .NUM_ZONES(4), .CNT_W(8), .ENTRY_DELAY(16), .SIREN_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm),
        .sensor(sensor), .zone_en(zone_en), .instant(instant),
`ifdef MULTI_ZONE_TAMPER_EN
        .tamper(tamper), .tamper_flag(tamper_flag),
`endif
        .alarm(alarm), .state(state), .zone_latch(zone_latch),
        .arm_fault(arm_fault), .count(count)
    );

    typedef struct {
        string       sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_v(input string s, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input string s);
        if (s == "state") return 32'(state);
        if (s == "alarm") return 32'(alarm);
        if (s == "count") return 32'(count);
        if (s == "latch") return 32'(zone_latch);
        if (s == "fault") return 32'(arm_fault);
`ifdef MULTI_ZONE_TAMPER_EN
        if (s == "tflag") return 32'(tamper_flag);
`endif
        return 'x;
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            n_checks++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.sig, o, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic exp_idle(input logic [31:0] st, input logic [31:0] lat);
        expect_v("state", st);
        expect_v("alarm", 0);
        expect_v("count", 0);
        expect_v("latch", lat);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; disarm = 1'b0;
        sensor = 4'h0; zone_en = 4'hF; instant = 4'h0;
`ifdef MULTI_ZONE_TAMPER_EN
        tamper = 1'b0;
`endif
        #12;
        exp_idle(0, 0);
        expect_v("fault", 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Arm with all zones quiet
        arm = 1'b1;
        exp_idle(1, 0);
        expect_v("fault", 0);
        step();
        arm = 1'b0;

        // Delayed zone 1: entry count 15..0, alarm on the 17th edge
        sensor = 4'b0010;
        expect_v("state", 2); expect_v("count", 15);
        step();
        sensor = 4'b0000;
        for (int k = 14; k >= 0; k--) begin
            expect_v("state", 2); expect_v("count", k); expect_v("alarm", 0);
            step();
        end
        expect_v("state", 3); expect_v("alarm", 1); expect_v("count", 63);
        expect_v("latch", 4'b0010);
        step();
        for (int k = 62; k >= 0; k--) begin
            expect_v("alarm", 1); expect_v("count", k);
            step();
        end
        exp_idle(4, 4'b0010);
        step();
        disarm = 1'b1;
        exp_idle(0, 4'b0010);
        step();
        disarm = 1'b0;

        // Instant zone 3, full siren, holdoff, re-trigger from zone 0
        arm = 1'b1;
        exp_idle(1, 0);
        step();
        arm = 1'b0;
        sensor = 4'b1000; instant = 4'b1000;
        expect_v("state", 3); expect_v("alarm", 1); expect_v("count", 63);
        expect_v("latch", 4'b1000);
        step();
        sensor = 4'b0000; instant = 4'b0000;
        for (int k = 62; k >= 0; k--) begin
            expect_v("alarm", 1); expect_v("state", 3); expect_v("count", k);
            step();
        end
        exp_idle(4, 4'b1000);
        step();
        exp_idle(4, 4'b1000);
        step();
        sensor = 4'b0001;
        expect_v("state", 3); expect_v("alarm", 1); expect_v("count", 63);
        expect_v("latch", 4'b1001);
        step();
        sensor = 4'b0000;
        expect_v("count", 62);
        step();

        // Disarm together with arm during entry
        disarm = 1'b1;
        exp_idle(0, 4'b1001);
        step();
        disarm = 1'b0;
        arm = 1'b1;
        exp_idle(1, 0);
        step();
        arm = 1'b0;
        sensor = 4'b0100;
        expect_v("state", 2); expect_v("count", 15); expect_v("latch", 4'b0100);
        step();
        sensor = 4'b0000;
        expect_v("count", 14);
        step();
        disarm = 1'b1; arm = 1'b1;
        exp_idle(0, 4'b0100);
        step();
        disarm = 1'b0;

        // Refused arm repeats while held, then masked zone arms cleanly
        sensor = 4'b0100;
        exp_idle(0, 4'b0100);
        expect_v("fault", 1);
        step();
        expect_v("fault", 1); expect_v("state", 0);
        step();
        arm = 1'b0;
        expect_v("fault", 0); expect_v("state", 0);
        step();
        zone_en = 4'b1011; arm = 1'b1;
        exp_idle(1, 0);
        expect_v("fault", 0);
        step();
        arm = 1'b0;
        exp_idle(1, 0);
        step();
        sensor = 4'b0000; zone_en = 4'hF;

        // Instant zone cuts the entry delay short
        sensor = 4'b0010;
        expect_v("state", 2); expect_v("count", 15);
        step();
        sensor = 4'b0000;
        expect_v("count", 14);
        step();
        sensor = 4'b0001; instant = 4'b0001;
        expect_v("state", 3); expect_v("alarm", 1); expect_v("count", 63);
        expect_v("latch", 4'b0011);
        step();
        sensor = 4'b0000; instant = 4'b0000;

        // Asynchronous reset mid-alarm
        #2;
        rst_n = 1'b0;
        #1;
        exp_idle(0, 0);
        expect_v("fault", 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MULTI_ZONE_TAMPER_EN
        tamper = 1'b1;
        expect_v("state", 3); expect_v("alarm", 1); expect_v("tflag", 1);
        expect_v("count", 63);
        step();
        tamper = 1'b0; disarm = 1'b1;
        exp_idle(0, 0);
        expect_v("tflag", 1);
        step();
        tamper = 1'b1;
        expect_v("state", 3); expect_v("alarm", 1);
        step();
        tamper = 1'b0;
        step();
        disarm = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
